// File: rtl/sdram_arb_pkg.sv
// Shared types and helpers for the SDRAM command-port arbiter.
package sdram_arb_pkg;

  typedef enum logic [0:0] {IDLE, OWN} arb_state_t;

  localparam int ARB_N  = 3;
  localparam int TAG_W  = $clog2(ARB_N);
  localparam int RR_MAX = 16;

  // First requesting index strictly after ptr, wrapping modulo n; ptr if none.
  function automatic int rr_pick(input logic [RR_MAX-1:0] req, input int ptr, input int n);
    int pick;
    int idx;
    logic found;
    pick  = ptr;
    found = 1'b0;
    for (int k = 1; k <= n; k++) begin
      idx = ptr + k;
      if (idx >= n) idx = idx - n;
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/arb_tag_fifo.sv
// Owner-tag FIFO: remembers which requester issued each outstanding read.
module arb_tag_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  // A pop in the same cycle frees the slot, so a push is allowed even when full.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign full     = (count == (PTR_W+1)'(DEPTH));
  assign empty    = (count == '0);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Round-robin, burst-bounded owner of the SDRAM controller command port.
// Optional ARB_URGENT_EN: camera (requester 0) gets strict priority and cuts other bursts short.
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int N         = ARB_N,
  parameter int ADDR_W    = 23,
  parameter int DATA_W    = 16,
  parameter int MAX_BURST = 64,
  parameter int TAG_DEPTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N-1:0]        iReq,
  input  logic [N-1:0]        iRd,
  input  logic [N-1:0]        iWr,
  input  logic [N*ADDR_W-1:0] iAddr,
  input  logic [N*DATA_W-1:0] iWdata,
  output logic [N-1:0]        oGnt,
  output logic [N-1:0]        oWait,
  output logic [DATA_W-1:0]   oRdata,
  output logic [N-1:0]        oRdValid,
  output logic                oSdramRd,
  output logic                oSdramWr,
  output logic [ADDR_W-1:0]   oSdramAddr,
  output logic [DATA_W-1:0]   oSdramWdata,
  input  logic                iSdramWait,
  input  logic [DATA_W-1:0]   iSdramRdata,
  input  logic                iSdramRdValid,
  output logic                oTagErr
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);

  arb_state_t       state;
  arb_state_t       state_nxt;
  logic [TAG_W-1:0] ptr;
  logic [TAG_W-1:0] ptr_nxt;
  logic [TAG_W-1:0] sel;
  logic [CNT_W-1:0] burst_cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] cnt_inc;
  logic [N-1:0]     gnt;
  logic [N-1:0]     gnt_nxt;

  logic             sdram_rd;
  logic             sdram_wr;
  logic             accepted;
  logic             release_own;
  logic             urgent_cut;

  logic             tag_full;
  logic             fifo_full;
  logic             fifo_empty;
  logic [TAG_W-1:0] tag_out;

  logic [N-1:0]      rd_valid;
  logic [DATA_W-1:0] rdata;
  logic              tag_err;

  assign oGnt        = gnt;
  assign oSdramRd    = sdram_rd;
  assign oSdramWr    = sdram_wr;
  assign oRdValid    = rd_valid;
  assign oRdata      = rdata;
  assign oTagErr     = tag_err;

  // A returning beat in this cycle frees a slot, so it does not count as full.
  assign tag_full = fifo_full & ~iSdramRdValid;
  assign accepted = (sdram_rd | sdram_wr) & ~iSdramWait;
  assign cnt_inc  = burst_cnt + 1'b1;

`ifdef ARB_URGENT_EN
  localparam logic [N-1:0] CAM_MASK = N'(1);
  assign sel        = iReq[0] ? '0
                    : TAG_W'(rr_pick(RR_MAX'(iReq & ~CAM_MASK), int'(ptr), N));
  assign urgent_cut = accepted & iReq[0] & (ptr != '0);
`else
  assign sel        = TAG_W'(rr_pick(RR_MAX'(iReq), int'(ptr), N));
  assign urgent_cut = 1'b0;
`endif

  assign release_own = (~iReq[ptr] & ~accepted)
                     | (accepted & (cnt_inc == CNT_W'(MAX_BURST)))
                     | urgent_cut;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= TAG_W'(N - 1);
      burst_cnt <= '0;
      gnt       <= '0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      burst_cnt <= cnt_nxt;
      gnt       <= gnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    cnt_nxt   = burst_cnt;
    gnt_nxt   = gnt;
    case (state)
      IDLE: begin
        if (|iReq) begin
          state_nxt    = OWN;
          ptr_nxt      = sel;
          cnt_nxt      = '0;
          gnt_nxt      = '0;
          gnt_nxt[sel] = 1'b1;
        end
      end
      OWN: begin
        if (accepted) cnt_nxt = cnt_inc;
        if (release_own) begin
          state_nxt = IDLE;
          gnt_nxt   = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // With read and write both raised the write goes out and the owner is told to wait.
  always_comb begin
    sdram_rd    = 1'b0;
    sdram_wr    = 1'b0;
    oSdramAddr  = '0;
    oSdramWdata = '0;
    if (state == OWN) begin
      sdram_wr    = iWr[ptr];
      sdram_rd    = iRd[ptr] & ~iWr[ptr] & ~tag_full;
      oSdramAddr  = iAddr[ptr*ADDR_W +: ADDR_W];
      oSdramWdata = iWdata[ptr*DATA_W +: DATA_W];
    end
    for (int i = 0; i < N; i++) begin
      oWait[i] = ~gnt[i] | iSdramWait | (iRd[i] & tag_full) | (gnt[i] & iRd[i] & iWr[i]);
    end
  end

  arb_tag_fifo #(
    .WIDTH (TAG_W),
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (sdram_rd & ~iSdramWait),
    .push_data (ptr),
    .pop       (iSdramRdValid),
    .pop_data  (tag_out),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // A beat with no outstanding tag has no destination: flag it and drop it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= '0;
      rdata    <= '0;
      tag_err  <= 1'b0;
    end else begin
      rd_valid <= '0;
      if (iSdramRdValid) begin
        if (fifo_empty) begin
          tag_err <= 1'b1;
        end else begin
          rd_valid[tag_out] <= 1'b1;
          rdata             <= iSdramRdata;
        end
      end
    end
  end

endmodule

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
Shares the single SDRAM controller command port among N requesters:
- req 0: camera frame write
- req 1: VGA display read
- req 2: image resizer read/write

It grants one owner at a time using round-robin arbitration with a bounded burst. The owner's command passes straight through to the SDRAM controller. Read data returning later is routed back to the requester that issued the read, using an owner-tag FIFO.

Parameters:
N, 3, number of requesters
ADDR_W, 23, SDRAM word address width
DATA_W, 16, data width
MAX_BURST, 64, accepted commands per grant before forced re-arbitration
TAG_DEPTH, 8, max outstanding reads (power of 2)

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
iReq  in  N  requester wants the port; held for the whole burst
iRd  in  N  read command from requester i
iWr  in  N  write command from requester i
iAddr  in  N*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
iWdata  in  N*DATA_W  packed write data
oGnt  out  N  one-hot grant, registered
oWait  out  N  per-requester stall; command not accepted this cycle
oRdata  out  DATA_W  read data, broadcast to all requesters
oRdValid  out  N  one-hot read-data strobe, to the requester that issued the read
oSdramRd  out  1  read strobe to SDRAM controller
oSdramWr  out  1  write strobe to SDRAM controller
oSdramAddr  out  ADDR_W  command address
oSdramWdata  out  DATA_W  write data
iSdramWait  in  1  controller wait-request
iSdramRdata  in  DATA_W  controller read data
iSdramRdValid  in  1  controller read-data valid
oTagErr  out  1  sticky: iSdramRdValid arrived with the tag FIFO empty

Behaviour:
- Reset values:
  - oGnt=0, oRdValid=0, oTagErr=0
  - oSdramRd=0, oSdramWr=0
  - oSdramAddr=0, oSdramWdata=0, oRdata=0
  - FSM in IDLE, round-robin pointer=N-1
  - tag FIFO empty, burst counter=0
- Reset mid-operation: outstanding tags are discarded; read data arriving after reset is ignored, and oTagErr is set if it arrives while the FIFO is empty.
- FSM state IDLE:
  - oGnt=0.
  - If any iReq is high, select the first requesting index after the pointer (wrapping modulo N).
  - Next cycle: oGnt=onehot(sel), state becomes OWN, burst counter=0, pointer=sel.
- FSM state OWN (owner o):
  - Command path is combinational: oSdramRd=iRd[o] & ~tagFull, oSdramWr=iWr[o], oSdramAddr=iAddr[o], oSdramWdata=iWdata[o].
  - iRd and iWr both high from the owner: the write wins and the read is held off (oWait[o]=1 for the read).
  - A command is accepted when (oSdramRd|oSdramWr) & ~iSdramWait.
  - oWait[i] = ~oGnt[i] | iSdramWait | (iRd[i] & tagFull).
  - Commands from non-owners are ignored.
- Release from OWN to IDLE (oGnt drops next cycle) when either:
  - iReq[o]=0 in a cycle with no accepted command, or
  - an accepted command makes the burst counter equal MAX_BURST.
- Every ownership change has a one-cycle IDLE gap. A sole requester is re-granted after the gap.
- Tag FIFO:
  - Push o on each accepted read.
  - Pop on iSdramRdValid; oRdValid[popped tag] pulses one cycle later with oRdata=iSdramRdata, both registered.
  - Push and pop in the same cycle are legal at any fill level.
  - Full: oSdramRd is suppressed.
  - Pop while empty: oTagErr is set (sticky until reset) and no oRdValid is issued.
- Tags outlive the grant: an owner may drop iReq with reads still outstanding, and its data is still routed to it.

Optional Feature:
- Macro ARB_URGENT_EN.
- Defined:
  - Requester 0 (camera) has strict priority in IDLE.
  - While another requester owns the port and iReq[0] is high, that owner's burst ends after its next accepted command.
  - Round robin applies only among requesters 1..N-1.
- Undefined: pure round robin, as described in Behaviour.

Decomposition:
- Package sdram_arb_pkg:
  - arb_state_t enum {IDLE, OWN}
  - localparam TAG_W = $clog2(N)
  - function rr_pick(req, ptr) returning the next index
- One sub-module: arb_tag_fifo (synchronous FIFO, width TAG_W, depth TAG_DEPTH, with full/empty flags).

Test Plan:
- Single requester: iReq[1]=1 at reset release, 10 reads with iSdramWait=0.
  - Required: oGnt=3'b010 one cycle after the request.
  - Required: 10 oSdramRd pulses; each iSdramRdValid returns as an oRdValid[1] pulse one cycle later.
- Round robin: all three iReq held, each burst 4 commands then iReq dropped.
  - Required grant order 0,1,2,0 with exactly one IDLE cycle between owners.
- Burst cap: MAX_BURST=64, requesters 1 and 2 both hold iReq with continuous writes.
  - Required: oGnt switches after exactly 64 accepted writes; no requester ever receives a 65th write within one grant.
- Tag FIFO full: TAG_DEPTH=8, 8 reads issued with no iSdramRdValid.
  - Required: 9th read is stalled (oWait[o]=1, oSdramRd=0).
  - Required: one iSdramRdValid frees a slot and the next read is accepted the same cycle as that pop.
- Cross-owner routing: req 2 issues 3 reads and releases; req 0 issues 2 reads; then 5 data beats return.
  - Required: oRdValid pattern 2,2,2,0,0.
- Reset and tag error: assert rst_n low during an OWN burst with reads pending, then return 2 iSdramRdValid beats after reset.
  - Required: oGnt=0 and no oRdValid pulses; oTagErr=1 after the first beat.
